hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Stall and sequencing controller for the 5-stage MIPS pipeline.
- Decodes the instructions held in D, E and M using the Tuse/Tnew model, and tracks a multi-cycle mult/div unit through an internal busy counter.
- Drives the bubble input of the D->E pipeline register and freezes PC and the F->D register while a hazard is unresolved.
- Sits in the top-level CPU beside the pipeline registers and the forwarding muxes.

Parameters:
- MULT_CYC, 5: busy cycles for mult/multu after issue into E.
- DIV_CYC, 10: busy cycles for div/divu after issue into E.
- CNT_W, 4: busy counter width; must satisfy 2^CNT_W > max(MULT_CYC, DIV_CYC).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- ir_d  in  32  instruction in D (F->D register output).
- ir_e  in  32  instruction in E (D->E register output).
- ir_m  in  32  instruction in M (E->M register output).
- stall  out  1  1 = insert bubble into D->E (all fields zeroed) this edge.
- pc_en  out  1  PC write enable; equals ~stall.
- fd_en  out  1  F->D register write enable; equals ~stall.
- md_busy  out  1  mult/div unit busy: counter nonzero or a md op in E.
- stall_cnt  out  32  stall-cycle counter (see Optional Feature).

Behaviour:
- Recognised ops: addu subu ori lw sw beq lui j jal jr mult multu div divu mfhi mflo mthi mtlo. Anything else is treated as nop: no source, no dest, Tnew 0.
- Dest register:
  - rd for addu/subu/mfhi/mflo.
  - rt for ori/lw/lui.
  - 31 for jal.
  - No dest for all other ops. A dest of $0 counts as no dest.
- Tuse:
  - beq rs/rt = 0; jr rs = 0.
  - addu/subu rs/rt = 1; ori/lw/sw/mthi/mtlo rs = 1; mult/div family rs/rt = 1.
  - sw rt = 2.
  - Unused source: Tuse = 3, which never stalls.
- Tnew in E: addu/subu/ori/lui/mfhi/mflo = 1; lw = 2; jal = 0.
- Tnew in M: lw = 1; all others = 0.
- Data stall when a D source equals a nonzero dest in E or M and Tuse < Tnew of that stage.
- md stall: the D instr is mult/multu/div/divu/mfhi/mflo/mthi/mtlo and md_busy = 1.
- stall = data stall OR md stall, combinational from the current inputs, forced to 0 while reset = 1.
- Busy counter:
  - Reset value 0.
  - At an edge where ir_e holds mult/multu, load MULT_CYC; div/divu, load DIV_CYC.
  - Otherwise decrement while nonzero. It saturates at 0, with no wrap.
- md_busy = (counter != 0) OR (ir_e is a mult/div op). A md op in E therefore blocks a following mfhi/mflo in D in the same cycle.
- A md op stays in E for exactly 1 cycle: a stall inserts a bubble behind it and never holds E.
- Simultaneous events: a new mult/div reaching E cannot occur while busy, because it is held in D. The load takes priority over decrement by definition.
- Reset mid-operation: the counter clears to 0 on the reset edge, md_busy = 0, stall = 0.
- Reset values: stall = 0, pc_en = 1, fd_en = 1, md_busy = 0, stall_cnt = 0.
- Latency: stall is the same cycle as the hazard; no registered path except the counters.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined: stall_cnt is a 32-bit register.
  - Cleared by reset; increments by 1 at every edge where stall = 1.
  - Wraps from 0xFFFFFFFF to 0.
- Undefined: stall_cnt is tied to 0 and no register is inferred. All other behaviour is identical.

Decomposition:
- Shared package/header `mips_defs`: opcode/funct constants, Tuse/Tnew encodings (2-bit), register number 31.
- One natural sub-module, `instr_class`: combinational decode of one instruction to rs, rt, dest, tuse_rs, tuse_rt, tnew, is_md, is_mult, is_div. Instantiated 3x (D, E, M).

Test Plan:
- lw $1,0($0) in E, addu $2,$1,$3 in D -> stall = 1, pc_en = 0 for 1 cycle. Next cycle lw is in M with Tnew 1, Tuse 1 -> stall = 0.
- ori $4,$0,5 in E, beq $4,$0 in D -> stall = 1 (Tuse 0 < Tnew 1). Next cycle ori in M -> stall = 0.
- mult $1,$2 reaches E, mflo $3 in D -> stall = 1 for the E cycle plus 5 counter cycles (6 total), md_busy falls after the 5th decrement, then mflo issues.
- div followed by an independent addu -> no stall. A mfhi arriving 4 cycles later still stalls until the 10 counter cycles expire.
- Dest $0: ori $0,$0,1 in E, addu $5,$0,$0 in D -> stall = 0. jal in E, jr $31 in D -> stall = 0 (Tnew 0).
- Reset asserted with counter = 7 -> next edge counter = 0, md_busy = 0, stall_cnt = 0. With HAZARD_PERF_EN, three stalled cycles -> stall_cnt = 3.

Source files
------------

// File: rtl/mips_defs.sv
// Shared MIPS decode constants for the hazard controller: opcodes, functs,
// decoded op classes and the 2-bit Tuse/Tnew encodings.
package mips_defs;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_MFHI  = 6'h10;
   localparam logic [5:0] FN_MTHI  = 6'h11;
   localparam logic [5:0] FN_MFLO  = 6'h12;
   localparam logic [5:0] FN_MTLO  = 6'h13;
   localparam logic [5:0] FN_MULT  = 6'h18;
   localparam logic [5:0] FN_MULTU = 6'h19;
   localparam logic [5:0] FN_DIV   = 6'h1A;
   localparam logic [5:0] FN_DIVU  = 6'h1B;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUBU  = 6'h23;

   localparam logic [4:0] REG_ZERO = 5'd0;
   localparam logic [4:0] REG_RA   = 5'd31;

   // Tuse 3 means "source not read"; it can never be below any Tnew.
   localparam logic [1:0] TUSE_0    = 2'd0;
   localparam logic [1:0] TUSE_1    = 2'd1;
   localparam logic [1:0] TUSE_2    = 2'd2;
   localparam logic [1:0] TUSE_NONE = 2'd3;

   localparam logic [1:0] TNEW_0 = 2'd0;
   localparam logic [1:0] TNEW_1 = 2'd1;
   localparam logic [1:0] TNEW_2 = 2'd2;

   typedef enum logic [4:0] {
      C_NOP   = 5'd0,
      C_ADDU  = 5'd1,
      C_SUBU  = 5'd2,
      C_ORI   = 5'd3,
      C_LW    = 5'd4,
      C_SW    = 5'd5,
      C_BEQ   = 5'd6,
      C_LUI   = 5'd7,
      C_J     = 5'd8,
      C_JAL   = 5'd9,
      C_JR    = 5'd10,
      C_MULT  = 5'd11,
      C_MULTU = 5'd12,
      C_DIV   = 5'd13,
      C_DIVU  = 5'd14,
      C_MFHI  = 5'd15,
      C_MFLO  = 5'd16,
      C_MTHI  = 5'd17,
      C_MTLO  = 5'd18
   } op_e;

   // Tnew seen one stage later: one cycle closer to the result, floored at 0.
   function automatic logic [1:0] tnew_age(input logic [1:0] t);
      if (t != TNEW_0) begin
         return t - 2'd1;
      end else begin
         return TNEW_0;
      end
   endfunction

endpackage

// File: rtl/instr_class.sv
// Combinational decode of one instruction into its source/dest registers,
// Tuse per source, E-stage Tnew and mult/div classification.
module instr_class
   import mips_defs::*;
(
   input  logic [31:0] instr_i,
   output logic [4:0]  rs_o,
   output logic [4:0]  rt_o,
   output logic [4:0]  dest_o,
   output logic [1:0]  tuse_rs_o,
   output logic [1:0]  tuse_rt_o,
   output logic [1:0]  tnew_o,
   output logic        is_md_o,
   output logic        is_mult_o,
   output logic        is_div_o
);

   logic [5:0] opcode_s;
   logic [5:0] funct_s;
   logic [4:0] rd_s;
   logic       unused_shamt_s;
   op_e        op_s;

   assign opcode_s       = instr_i[31:26];
   assign rs_o           = instr_i[25:21];
   assign rt_o           = instr_i[20:16];
   assign rd_s           = instr_i[15:11];
   assign funct_s        = instr_i[5:0];
   assign unused_shamt_s = ^instr_i[10:6];

   // Map opcode/funct to an op class; anything unrecognised becomes a nop.
   always_comb begin
      op_s = C_NOP;
      case (opcode_s)
         OP_RTYPE: begin
            case (funct_s)
               FN_ADDU:  op_s = C_ADDU;
               FN_SUBU:  op_s = C_SUBU;
               FN_JR:    op_s = C_JR;
               FN_MULT:  op_s = C_MULT;
               FN_MULTU: op_s = C_MULTU;
               FN_DIV:   op_s = C_DIV;
               FN_DIVU:  op_s = C_DIVU;
               FN_MFHI:  op_s = C_MFHI;
               FN_MFLO:  op_s = C_MFLO;
               FN_MTHI:  op_s = C_MTHI;
               FN_MTLO:  op_s = C_MTLO;
               default:  op_s = C_NOP;
            endcase
         end
         OP_ORI:  op_s = C_ORI;
         OP_LW:   op_s = C_LW;
         OP_SW:   op_s = C_SW;
         OP_BEQ:  op_s = C_BEQ;
         OP_LUI:  op_s = C_LUI;
         OP_J:    op_s = C_J;
         OP_JAL:  op_s = C_JAL;
         default: op_s = C_NOP;
      endcase
   end

   // Per-class hazard attributes; REG_ZERO as dest means "writes nothing".
   always_comb begin
      dest_o    = REG_ZERO;
      tuse_rs_o = TUSE_NONE;
      tuse_rt_o = TUSE_NONE;
      tnew_o    = TNEW_0;
      is_md_o   = 1'b0;
      is_mult_o = 1'b0;
      is_div_o  = 1'b0;
      case (op_s)
         C_ADDU, C_SUBU: begin
            dest_o    = rd_s;
            tuse_rs_o = TUSE_1;
            tuse_rt_o = TUSE_1;
            tnew_o    = TNEW_1;
         end
         C_ORI: begin
            dest_o    = rt_o;
            tuse_rs_o = TUSE_1;
            tnew_o    = TNEW_1;
         end
         C_LW: begin
            dest_o    = rt_o;
            tuse_rs_o = TUSE_1;
            tnew_o    = TNEW_2;
         end
         C_SW: begin
            tuse_rs_o = TUSE_1;
            tuse_rt_o = TUSE_2;
         end
         C_BEQ: begin
            tuse_rs_o = TUSE_0;
            tuse_rt_o = TUSE_0;
         end
         C_LUI: begin
            dest_o = rt_o;
            tnew_o = TNEW_1;
         end
         C_JAL: begin
            dest_o = REG_RA;
            tnew_o = TNEW_0;
         end
         C_JR: begin
            tuse_rs_o = TUSE_0;
         end
         C_MULT, C_MULTU: begin
            tuse_rs_o = TUSE_1;
            tuse_rt_o = TUSE_1;
            is_md_o   = 1'b1;
            is_mult_o = 1'b1;
         end
         C_DIV, C_DIVU: begin
            tuse_rs_o = TUSE_1;
            tuse_rt_o = TUSE_1;
            is_md_o   = 1'b1;
            is_div_o  = 1'b1;
         end
         C_MFHI, C_MFLO: begin
            dest_o  = rd_s;
            tnew_o  = TNEW_1;
            is_md_o = 1'b1;
         end
         C_MTHI, C_MTLO: begin
            tuse_rs_o = TUSE_1;
            is_md_o   = 1'b1;
         end
         default: begin
            dest_o = REG_ZERO;
         end
      endcase
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Tuse/Tnew stall controller with mult/div busy tracking for the 5-stage MIPS pipe.
// Define HAZARD_PERF_EN to get a live stall-cycle counter on stall_cnt.
module hazard_ctrl
   import mips_defs::*;
#(
   parameter int MULT_CYC = 5,
   parameter int DIV_CYC  = 10,
   parameter int CNT_W    = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] ir_d,
   input  logic [31:0] ir_e,
   input  logic [31:0] ir_m,
   output logic        stall,
   output logic        pc_en,
   output logic        fd_en,
   output logic        md_busy,
   output logic [31:0] stall_cnt
);

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MULT = CNT_W'(MULT_CYC);
   localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(DIV_CYC);

   logic [4:0] d_rs_s, d_rt_s, d_dest_s, e_rs_s, e_rt_s, e_dest_s, m_rs_s, m_rt_s, m_dest_s;
   logic [1:0] d_tuse_rs_s, d_tuse_rt_s, d_tnew_s;
   logic [1:0] e_tuse_rs_s, e_tuse_rt_s, e_tnew_s;
   logic [1:0] m_tuse_rs_s, m_tuse_rt_s, m_tnew_raw_s, m_tnew_s;
   logic       d_is_md_s, d_is_mult_s, d_is_div_s;
   logic       e_is_md_s, e_is_mult_s, e_is_div_s;
   logic       m_is_md_s, m_is_mult_s, m_is_div_s;
   logic       data_stall_s, md_busy_s, stall_s;
   logic       unused_dec_s;
   logic [CNT_W-1:0] busy_cnt_q, busy_cnt_d;

   instr_class u_dec_d (
      .instr_i(ir_d), .rs_o(d_rs_s), .rt_o(d_rt_s), .dest_o(d_dest_s),
      .tuse_rs_o(d_tuse_rs_s), .tuse_rt_o(d_tuse_rt_s), .tnew_o(d_tnew_s),
      .is_md_o(d_is_md_s), .is_mult_o(d_is_mult_s), .is_div_o(d_is_div_s)
   );

   instr_class u_dec_e (
      .instr_i(ir_e), .rs_o(e_rs_s), .rt_o(e_rt_s), .dest_o(e_dest_s),
      .tuse_rs_o(e_tuse_rs_s), .tuse_rt_o(e_tuse_rt_s), .tnew_o(e_tnew_s),
      .is_md_o(e_is_md_s), .is_mult_o(e_is_mult_s), .is_div_o(e_is_div_s)
   );

   instr_class u_dec_m (
      .instr_i(ir_m), .rs_o(m_rs_s), .rt_o(m_rt_s), .dest_o(m_dest_s),
      .tuse_rs_o(m_tuse_rs_s), .tuse_rt_o(m_tuse_rt_s), .tnew_o(m_tnew_raw_s),
      .is_md_o(m_is_md_s), .is_mult_o(m_is_mult_s), .is_div_o(m_is_div_s)
   );

   assign unused_dec_s = ^{d_dest_s, d_tnew_s, d_is_mult_s, d_is_div_s,
                           e_rs_s, e_rt_s, e_tuse_rs_s, e_tuse_rt_s, e_is_md_s,
                           m_rs_s, m_rt_s, m_tuse_rs_s, m_tuse_rt_s,
                           m_is_md_s, m_is_mult_s, m_is_div_s};

   // Decoder reports E-stage Tnew; M-stage producers are one cycle further along.
   assign m_tnew_s = tnew_age(m_tnew_raw_s);

   // A D source stalls when it matches a live dest whose result arrives too late.
   always_comb begin
      data_stall_s = 1'b0;
      if ((e_dest_s != REG_ZERO) &&
          (((d_rs_s == e_dest_s) && (d_tuse_rs_s < e_tnew_s)) ||
           ((d_rt_s == e_dest_s) && (d_tuse_rt_s < e_tnew_s)))) begin
         data_stall_s = 1'b1;
      end else if ((m_dest_s != REG_ZERO) &&
          (((d_rs_s == m_dest_s) && (d_tuse_rs_s < m_tnew_s)) ||
           ((d_rt_s == m_dest_s) && (d_tuse_rt_s < m_tnew_s)))) begin
         data_stall_s = 1'b1;
      end else begin
         data_stall_s = 1'b0;
      end
   end

   assign md_busy_s = (busy_cnt_q != CNT_ZERO) | e_is_mult_s | e_is_div_s;
   assign stall_s   = ~reset & (data_stall_s | (d_is_md_s & md_busy_s));
   assign stall     = stall_s;
   assign pc_en     = ~stall_s;
   assign fd_en     = ~stall_s;
   assign md_busy   = ~reset & md_busy_s;

   // A new mult/div in E reloads the busy count; otherwise count down to 0.
   always_comb begin
      if (e_is_mult_s) begin
         busy_cnt_d = CNT_MULT;
      end else if (e_is_div_s) begin
         busy_cnt_d = CNT_DIV;
      end else if (busy_cnt_q != CNT_ZERO) begin
         busy_cnt_d = busy_cnt_q - CNT_ONE;
      end else begin
         busy_cnt_d = busy_cnt_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         busy_cnt_q <= CNT_ZERO;
      end else begin
         busy_cnt_q <= busy_cnt_d;
      end
   end

`ifdef HAZARD_PERF_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   assign stall_cnt_d = stall_s ? (stall_cnt_q + 32'd1) : stall_cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= 32'd0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
`else
   assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a mnemonic-level pipeline model predicts
// stall/md_busy/stall_cnt each cycle, a monitor compares at the falling edge.
module tb_hazard_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] ir_d, ir_e, ir_m;
   logic        stall, pc_en, fd_en, md_busy;
   logic [31:0] stall_cnt;

   always #5 clk = ~clk;

   hazard_ctrl #(.MULT_CYC(5), .DIV_CYC(10), .CNT_W(4)) dut (
      .clk(clk), .reset(reset), .ir_d(ir_d), .ir_e(ir_e), .ir_m(ir_m),
      .stall(stall), .pc_en(pc_en), .fd_en(fd_en), .md_busy(md_busy),
      .stall_cnt(stall_cnt)
   );

   typedef enum int {
      K_NOP, K_ADDU, K_SUBU, K_ORI, K_LW, K_SW, K_BEQ, K_LUI, K_J, K_JAL, K_JR,
      K_MULT, K_MULTU, K_DIV, K_DIVU, K_MFHI, K_MFLO, K_MTHI, K_MTLO, K_OTHER
   } kind_e;

   typedef struct {
      kind_e k;
      int    rs;
      int    rt;
      int    rd;
   } ins_t;

   typedef struct {
      bit          st;
      bit          busy;
      logic [31:0] cnt;
      int          cyc;
   } exp_t;

   exp_t exp_q[$];
   ins_t fetch_q[$];
   ins_t pd, pe, pm;
   int   m_busy_left;
   int   m_perf;
   int   cyc;
   int   checks = 0;
   int   errors = 0;

   function automatic ins_t mk(kind_e k, int rs, int rt, int rd);
      ins_t i;
      i.k = k; i.rs = rs; i.rt = rt; i.rd = rd;
      return i;
   endfunction

   function automatic ins_t nop();
      return mk(K_NOP, 0, 0, 0);
   endfunction

   function automatic logic [31:0] enc(ins_t i);
      logic [4:0] s, t, d;
      s = i.rs[4:0]; t = i.rt[4:0]; d = i.rd[4:0];
      case (i.k)
         K_ADDU:  return {6'h00, s, t, d, 5'h00, 6'h21};
         K_SUBU:  return {6'h00, s, t, d, 5'h00, 6'h23};
         K_ORI:   return {6'h0D, s, t, 16'h0005};
         K_LW:    return {6'h23, s, t, 16'h0010};
         K_SW:    return {6'h2B, s, t, 16'h0020};
         K_BEQ:   return {6'h04, s, t, 16'hFFFC};
         K_LUI:   return {6'h0F, 5'd0, t, 16'h1234};
         K_J:     return {6'h02, 26'h0000100};
         K_JAL:   return {6'h03, 26'h0000200};
         K_JR:    return {6'h00, s, 5'd0, 5'd0, 5'd0, 6'h08};
         K_MULT:  return {6'h00, s, t, 5'd0, 5'd0, 6'h18};
         K_MULTU: return {6'h00, s, t, 5'd0, 5'd0, 6'h19};
         K_DIV:   return {6'h00, s, t, 5'd0, 5'd0, 6'h1A};
         K_DIVU:  return {6'h00, s, t, 5'd0, 5'd0, 6'h1B};
         K_MFHI:  return {6'h00, 5'd0, 5'd0, d, 5'd0, 6'h10};
         K_MFLO:  return {6'h00, 5'd0, 5'd0, d, 5'd0, 6'h12};
         K_MTHI:  return {6'h00, s, 5'd0, 5'd0, 5'd0, 6'h11};
         K_MTLO:  return {6'h00, s, 5'd0, 5'd0, 5'd0, 6'h13};
         K_OTHER: return {6'h00, s, t, d, 5'd3, 6'h24};
         default: return 32'h0000_0000;
      endcase
   endfunction

   function automatic int dest_of(ins_t i);
      case (i.k)
         K_ADDU, K_SUBU, K_MFHI, K_MFLO: return i.rd;
         K_ORI, K_LW, K_LUI:             return i.rt;
         K_JAL:                          return 31;
         default:                        return 0;
      endcase
   endfunction

   function automatic int tuse_rs(kind_e k);
      case (k)
         K_BEQ, K_JR: return 0;
         K_ADDU, K_SUBU, K_ORI, K_LW, K_SW, K_MTHI, K_MTLO,
         K_MULT, K_MULTU, K_DIV, K_DIVU: return 1;
         default: return 3;
      endcase
   endfunction

   function automatic int tuse_rt(kind_e k);
      case (k)
         K_BEQ: return 0;
         K_ADDU, K_SUBU, K_MULT, K_MULTU, K_DIV, K_DIVU: return 1;
         K_SW: return 2;
         default: return 3;
      endcase
   endfunction

   function automatic int tnew_in_e(kind_e k);
      case (k)
         K_ADDU, K_SUBU, K_ORI, K_LUI, K_MFHI, K_MFLO: return 1;
         K_LW: return 2;
         default: return 0;
      endcase
   endfunction

   function automatic int tnew_in_m(kind_e k);
      return (k == K_LW) ? 1 : 0;
   endfunction

   function automatic bit is_mult(kind_e k);
      return (k == K_MULT) || (k == K_MULTU);
   endfunction

   function automatic bit is_div(kind_e k);
      return (k == K_DIV) || (k == K_DIVU);
   endfunction

   function automatic bit uses_md(kind_e k);
      return is_mult(k) || is_div(k) || (k == K_MFHI) || (k == K_MFLO) ||
             (k == K_MTHI) || (k == K_MTLO);
   endfunction

   function automatic bit conflict(ins_t d, ins_t p, int tnew);
      int dst;
      dst = dest_of(p);
      if (dst == 0) return 1'b0;
      return ((d.rs == dst) && (tuse_rs(d.k) < tnew)) ||
             ((d.rt == dst) && (tuse_rt(d.k) < tnew));
   endfunction

   function automatic int rand_reg();
      if ($urandom_range(0, 7) == 0) return 31;
      return int'($urandom_range(0, 4));
   endfunction

   function automatic ins_t rand_ins();
      return mk(kind_e'($urandom_range(0, 19)), rand_reg(), rand_reg(), rand_reg());
   endfunction

   task automatic step(input bit rst);
      exp_t e;
      bit   busy, st;
      reset = rst;
      ir_d  = enc(pd);
      ir_e  = enc(pe);
      ir_m  = enc(pm);
      busy  = (m_busy_left != 0) || is_mult(pe.k) || is_div(pe.k);
      st    = conflict(pd, pe, tnew_in_e(pe.k)) || conflict(pd, pm, tnew_in_m(pm.k)) ||
              (uses_md(pd.k) && busy);
      if (rst) begin
         st   = 1'b0;
         busy = 1'b0;
      end
      e.st   = st;
      e.busy = busy;
`ifdef HAZARD_PERF_EN
      e.cnt  = m_perf;
`else
      e.cnt  = 32'd0;
`endif
      e.cyc  = cyc;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      cyc++;
      if (rst) begin
         m_busy_left = 0;
         m_perf      = 0;
         pd = nop(); pe = nop(); pm = nop();
      end else begin
         if (is_mult(pe.k)) m_busy_left = 5;
         else if (is_div(pe.k)) m_busy_left = 10;
         else if (m_busy_left > 0) m_busy_left--;
         if (st) m_perf++;
         pm = pe;
         if (st) begin
            pe = nop();
         end else begin
            pe = pd;
            pd = (fetch_q.size() > 0) ? fetch_q.pop_front() : nop();
         end
      end
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) fetch_q.push_back(nop());
   endtask

   task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, want);
      end
   endtask

   // Monitor: compare each cycle's outputs against the queued prediction.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("stall",     e.cyc, {31'd0, stall},   {31'd0, e.st});
            chk("pc_en",     e.cyc, {31'd0, pc_en},   {31'd0, ~e.st});
            chk("fd_en",     e.cyc, {31'd0, fd_en},   {31'd0, ~e.st});
            chk("md_busy",   e.cyc, {31'd0, md_busy}, {31'd0, e.busy});
            chk("stall_cnt", e.cyc, stall_cnt,        e.cnt);
         end
      end
   end

   initial begin
      cyc = 0;
      m_busy_left = 0;
      m_perf = 0;
      reset = 1'b1;
      ir_d = 32'd0; ir_e = 32'd0; ir_m = 32'd0;
      @(posedge clk);
      #1;
      // Reset with a mult in E and a dependent mfhi in D: outputs must stay idle.
      pm = mk(K_LW, 0, 1, 0);
      pe = mk(K_MULT, 1, 2, 0);
      pd = mk(K_MFHI, 0, 0, 3);
      step(1'b1);
      step(1'b1);

      fetch_q.push_back(mk(K_LW, 0, 1, 0));
      fetch_q.push_back(mk(K_ADDU, 1, 3, 2));
      drain(3);
      fetch_q.push_back(mk(K_ORI, 0, 4, 0));
      fetch_q.push_back(mk(K_BEQ, 4, 0, 0));
      drain(3);
      fetch_q.push_back(mk(K_MULT, 1, 2, 0));
      fetch_q.push_back(mk(K_MFLO, 0, 0, 3));
      drain(3);
      fetch_q.push_back(mk(K_DIV, 1, 2, 0));
      fetch_q.push_back(mk(K_ADDU, 6, 7, 5));
      drain(3);
      fetch_q.push_back(mk(K_MFHI, 0, 0, 8));
      drain(3);
      fetch_q.push_back(mk(K_ORI, 0, 0, 0));
      fetch_q.push_back(mk(K_ADDU, 0, 0, 5));
      fetch_q.push_back(mk(K_JAL, 0, 0, 0));
      fetch_q.push_back(mk(K_JR, 31, 0, 0));
      drain(3);
      for (int i = 0; i < 80 && fetch_q.size() > 0; i++) step(1'b0);
      for (int i = 0; i < 4; i++) step(1'b0);

      // Reset while the busy counter is mid-count at 7.
      fetch_q.push_back(mk(K_DIVU, 2, 3, 0));
      drain(2);
      for (int i = 0; i < 30 && m_busy_left != 7; i++) step(1'b0);
      step(1'b1);
      fetch_q.push_back(mk(K_MFLO, 0, 0, 4));
      drain(2);
      for (int i = 0; i < 4; i++) step(1'b0);

      for (int i = 0; i < 1500; i++) begin
         if (fetch_q.size() < 2) fetch_q.push_back(rand_ins());
         step($urandom_range(0, 99) == 0);
      end

      for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
